// File: rtl/eth_tx_arb.sv
// Packet-granular round-robin arbiter feeding one TX MAC nibble stream from N_SRC FWFT sources.
// Truncates packets longer than MAX_NIBBLES, discards their tail, and keeps per-source statistics.
module eth_tx_arb #(
    parameter int N_SRC       = 2,
    parameter int MAX_NIBBLES = 3036,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_tx,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src_vld,
    input  logic [4*N_SRC-1:0]     src_dat,
    input  logic [N_SRC-1:0]       src_eof,
    output logic [N_SRC-1:0]       src_ack,
    output logic                   tx_vld,
    output logic [3:0]             tx_dat,
    output logic                   tx_eof,
    input  logic                   tx_ack,
    output logic [N_SRC-1:0]       grant,
    output logic [CNT_W*N_SRC-1:0] pkt_cnt,
    output logic [CNT_W-1:0]       trunc_cnt,
    output logic [CNT_W-1:0]       urun_cnt
);
    localparam int IDX_W = $clog2(N_SRC);
    localparam int NIB_W = $clog2(MAX_NIBBLES + 1);
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(MAX_NIBBLES - 1);
    localparam logic [NIB_W-1:0] NIB_SAT  = NIB_W'(MAX_NIBBLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [N_SRC-1:0] r_grant, w_grant_next;
    logic [IDX_W-1:0] r_last, w_last_next;
    logic [NIB_W-1:0] r_nib, w_nib_next;
    logic [CNT_W-1:0] r_trunc_cnt, r_urun_cnt;

    logic             w_g_vld, w_g_eof;
    logic [3:0]       w_g_dat;
    logic             w_req_found;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_force, w_fwd_beat, w_drain_beat, w_pkt_done, w_trunc, w_urun;

    // r_last always names the granted source while in FWD/DRAIN.
    always_comb begin
        w_g_vld = 1'b0;
        w_g_eof = 1'b0;
        w_g_dat = 4'h0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_last == IDX_W'(i)) begin
                w_g_vld = src_vld[i];
                w_g_eof = src_eof[i];
                w_g_dat = src_dat[4*i +: 4];
            end
        end
    end

    always_comb begin : p_rr
        int cand;
        w_req_found = 1'b0;
        w_req_idx   = r_last;
        cand        = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = (int'(r_last) + k) % N_SRC;
            if (!w_req_found && src_vld[cand]) begin
                w_req_found = 1'b1;
                w_req_idx   = IDX_W'(cand);
            end
        end
    end

    assign w_force      = (r_nib == NIB_LAST);
    assign w_fwd_beat   = (r_state == ST_FWD) && w_g_vld && tx_ack;
    assign w_drain_beat = (r_state == ST_DRAIN) && w_g_vld;
    assign w_pkt_done   = (w_fwd_beat || w_drain_beat) && w_g_eof;
    assign w_trunc      = w_fwd_beat && w_force && !w_g_eof;
    assign w_urun       = (r_state == ST_FWD) && !w_g_vld;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_nib_next   = r_nib;
        case (r_state)
            ST_IDLE: begin
                if (w_req_found) begin
                    w_state_next = ST_FWD;
                    w_grant_next = {{(N_SRC-1){1'b0}}, 1'b1} << w_req_idx;
                    w_last_next  = w_req_idx;
                    w_nib_next   = '0;
                end
            end
            ST_FWD: begin
                if (w_fwd_beat && (r_nib != NIB_SAT)) begin
                    w_nib_next = r_nib + 1'b1;
                end
                if (w_pkt_done) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                end else if (w_trunc) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pkt_done) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_last      <= IDX_W'(N_SRC - 1);
            r_nib       <= '0;
            r_trunc_cnt <= '0;
            r_urun_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_nib   <= w_nib_next;
            if (w_trunc) begin
                r_trunc_cnt <= r_trunc_cnt + 1'b1;
            end
            if (w_urun) begin
                r_urun_cnt <= r_urun_cnt + 1'b1;
            end
        end
    end

    // Per-source ack and packet counter; DRAIN discards without waiting on the MAC.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        logic [CNT_W-1:0] r_pkt;

        always_ff @(posedge clk_tx) begin
            if (rst) begin
                r_pkt <= '0;
            end else if (w_pkt_done && (r_last == IDX_W'(gi))) begin
                r_pkt <= r_pkt + 1'b1;
            end
        end

        assign pkt_cnt[CNT_W*gi +: CNT_W] = r_pkt;
        assign src_ack[gi] = r_grant[gi] &
                             (((r_state == ST_FWD) && tx_ack) ||
                              ((r_state == ST_DRAIN) && src_vld[gi]));
    end

    assign tx_vld    = (r_state == ST_FWD) && w_g_vld;
    assign tx_dat    = (r_state == ST_FWD) ? w_g_dat : 4'h0;
    assign tx_eof    = (r_state == ST_FWD) && (w_g_eof || w_force);
    assign grant     = r_grant;
    assign trunc_cnt = r_trunc_cnt;
    assign urun_cnt  = r_urun_cnt;

endmodule
